// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared widths and helpers for the divide arbiter
package fp_div_pkg;
    localparam int FP_W = 32;
    typedef logic [FP_W-1:0] fp_t;
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fp_div_tag_fifo.sv
// fp_div_tag_fifo: synchronous FIFO of requester ids in issue order
module fp_div_tag_fifo #(
    parameter int DEPTH = 32,
    parameter int W     = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok, pop_ok;
    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
    // pointer and count update; a simultaneous push and pop leaves the count unchanged
    always_comb begin
        push_ok = push_i && !full_o;
        pop_ok  = pop_i && !empty_o;
        wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d    = pop_ok ? rd_q + 1'b1 : rd_q;
        cnt_d   = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
    // pointer state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    // storage needs no reset; only pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: round-robin sharing of one AXI-stream divide IP among requesters
module fp_div_arbiter
    import fp_div_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MAX_OUT = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*FP_W-1:0] req_a,
    input  logic [NUM_REQ*FP_W-1:0] req_b,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [FP_W-1:0]         rsp_data,
    output logic [FP_W-1:0]         s_axis_a_tdata,
    output logic                    s_axis_a_tvalid,
    input  logic                    s_axis_a_tready,
    output logic [FP_W-1:0]         s_axis_b_tdata,
    output logic                    s_axis_b_tvalid,
    input  logic                    s_axis_b_tready,
    input  logic [FP_W-1:0]         m_axis_result_tdata,
    input  logic                    m_axis_result_tvalid,
    output logic                    m_axis_result_tready,
    output logic                    busy,
    output logic                    orphan
);
    localparam int IDW = id_w(NUM_REQ);
    localparam int CW  = $clog2(MAX_OUT) + 1;

    logic           live_q;
    logic           en;
    logic [IDW-1:0] last_q, last_d;
    logic           iss_vld_q, iss_vld_d;
    logic           a_done_q, a_done_d, b_done_q, b_done_d;
    fp_t            iss_a_q, iss_a_d, iss_b_q, iss_b_d;
    logic [IDW-1:0] iss_id_q, iss_id_d;
    logic           a_hs, b_hs, iss_free;
    logic           gnt_vld, take;
    logic [IDW-1:0] gnt_id;
    logic [CW-1:0]  fifo_cnt, outstanding;
    logic [IDW-1:0] head;
    logic           fifo_full, fifo_empty, pop;

    // outputs stay quiet during reset and the first cycle after release
    assign en              = rstn && live_q;
    assign s_axis_a_tvalid = en && iss_vld_q && !a_done_q;
    assign s_axis_b_tvalid = en && iss_vld_q && !b_done_q;
    assign s_axis_a_tdata  = iss_a_q;
    assign s_axis_b_tdata  = iss_b_q;
    assign a_hs            = s_axis_a_tvalid && s_axis_a_tready;
    assign b_hs            = s_axis_b_tvalid && s_axis_b_tready;
    assign iss_free        = iss_vld_q && (a_done_q || a_hs) && (b_done_q || b_hs);
    assign outstanding     = fifo_cnt + CW'(iss_vld_q);
    assign busy            = en && outstanding != '0;

    // round-robin search from last_grant+1; credit ignores same-cycle pops
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!gnt_vld && req_valid[(int'(last_q) + k) % NUM_REQ]) begin
                gnt_vld = 1'b1;
                gnt_id  = IDW'((int'(last_q) + k) % NUM_REQ);
            end
        end
        take      = en && gnt_vld && (!iss_vld_q || iss_free) && outstanding < CW'(MAX_OUT) && !fifo_full;
        req_ready = take ? NUM_REQ'(1) << gnt_id : '0;
    end

    // issue register: frees when both channels have handshaken, reloads in the same cycle
    always_comb begin
        iss_vld_d = iss_free ? 1'b0 : iss_vld_q;
        a_done_d  = iss_free ? 1'b0 : a_done_q || a_hs;
        b_done_d  = iss_free ? 1'b0 : b_done_q || b_hs;
        iss_a_d   = iss_a_q;
        iss_b_d   = iss_b_q;
        iss_id_d  = iss_id_q;
        last_d    = last_q;
        if (take) begin
            iss_vld_d = 1'b1;
            a_done_d  = 1'b0;
            b_done_d  = 1'b0;
            iss_a_d   = req_a[gnt_id*FP_W +: FP_W];
            iss_b_d   = req_b[gnt_id*FP_W +: FP_W];
            iss_id_d  = gnt_id;
            last_d    = gnt_id;
        end
    end

    // control state; requester 0 gets first priority after reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            live_q    <= 1'b0;
            iss_vld_q <= 1'b0;
            a_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            last_q    <= IDW'(NUM_REQ - 1);
        end else begin
            live_q    <= 1'b1;
            iss_vld_q <= iss_vld_d;
            a_done_q  <= a_done_d;
            b_done_q  <= b_done_d;
            last_q    <= last_d;
        end
    end

    // operand payload is qualified by iss_vld_q and needs no reset
    always_ff @(posedge clk) begin
        iss_a_q  <= iss_a_d;
        iss_b_q  <= iss_b_d;
        iss_id_q <= iss_id_d;
    end

    fp_div_tag_fifo #(.DEPTH(MAX_OUT), .W(IDW), .CW(CW)) u_tags (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (iss_free),
        .data_i  (iss_id_q),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // results route to the head tag; untagged results are accepted and dropped
    always_comb begin
        m_axis_result_tready = en && (fifo_empty || rsp_ready[head]);
        pop                  = m_axis_result_tvalid && m_axis_result_tready && !fifo_empty;
        orphan               = en && m_axis_result_tvalid && fifo_empty;
        rsp_valid            = (en && m_axis_result_tvalid && !fifo_empty) ? NUM_REQ'(1) << head : '0;
        rsp_data             = m_axis_result_tdata;
    end
endmodule

// File: tb/tb_fp_div_arbiter.sv
// tb_fp_div_arbiter: directed checks of the divide arbiter against a latency-L IP model
module tb_fp_div_arbiter;
    localparam int N = 4;
    localparam int L = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic [N-1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*32-1:0] req_a, req_b;
    logic [31:0]   rsp_data, a_tdata, b_tdata;
    logic          a_tvalid, b_tvalid, a_rdy, b_rdy;
    logic          r_valid = 1'b0;
    logic [31:0]   r_data = 32'h0;
    logic          r_ready, busy, orphan;

    logic [31:0] qa[$], qb[$], qr[$];
    int          qt[$];
    int          gq[$], gc[$], rq_id[$];
    logic [31:0] rq_d[$];
    int cyc = 0, na = 0, nb = 0, n_orph = 0, n_viol = 0;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    fp_div_arbiter #(.NUM_REQ(N), .MAX_OUT(32)) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_a                (req_a),
        .req_b                (req_b),
        .rsp_valid            (rsp_valid),
        .rsp_ready            (rsp_ready),
        .rsp_data             (rsp_data),
        .s_axis_a_tdata       (a_tdata),
        .s_axis_a_tvalid      (a_tvalid),
        .s_axis_a_tready      (a_rdy),
        .s_axis_b_tdata       (b_tdata),
        .s_axis_b_tvalid      (b_tvalid),
        .s_axis_b_tready      (b_rdy),
        .m_axis_result_tdata  (r_data),
        .m_axis_result_tvalid (r_valid),
        .m_axis_result_tready (r_ready),
        .busy                 (busy),
        .orphan               (orphan)
    );

    function automatic logic [31:0] ip_div(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        if (a == 32'h3F800000 && b == 32'h00000000) return 32'h7F800000;
        return a ^ {b[15:0], b[31:16]};
    endfunction

    function automatic int first1(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // divide IP model (never reset) plus grant/response/orphan logging
    always @(posedge clk) begin
        cyc++;
        if (a_tvalid && a_rdy) begin qa.push_back(a_tdata); na++; end
        if (b_tvalid && b_rdy) begin qb.push_back(b_tdata); nb++; end
        if (r_valid && r_ready) begin void'(qr.pop_front()); void'(qt.pop_front()); end
        while (qa.size() > 0 && qb.size() > 0) begin
            qr.push_back(ip_div(qa.pop_front(), qb.pop_front()));
            qt.push_back(cyc + L);
        end
        r_valid <= (qr.size() > 0) ? (qt[0] <= cyc) : 1'b0;
        r_data  <= (qr.size() > 0) ? qr[0] : 32'h0;
        if (|req_ready) begin gq.push_back(first1(req_ready)); gc.push_back(cyc); end
        if (|(rsp_valid & rsp_ready)) begin rq_id.push_back(first1(rsp_valid)); rq_d.push_back(rsp_data); end
        if (orphan) n_orph++;
        if ($countones(req_ready) > 1 || $countones(rsp_valid) > 1) n_viol++;
    end

    task automatic do_reset();
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic clr_logs();
        gq.delete(); gc.delete(); rq_id.delete(); rq_d.delete();
    endtask

    initial begin
        rstn = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        rsp_ready = '1; a_rdy = 1'b1; b_rdy = 1'b1;
        // reset state and single request
        req_valid = 4'b0001;
        req_a[31:0] = 32'h40C00000;
        req_b[31:0] = 32'h40000000;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_outs", 64'({rsp_valid, a_tvalid, b_tvalid, busy, orphan}), 64'(0));
        rstn = 1'b1;
        #1 chk("rel_outs", 64'({req_ready, rsp_valid, a_tvalid, b_tvalid, busy, orphan}), 64'(0));
        @(negedge clk);
        chk("t1_grant", 64'(req_ready), 64'(4'b0001));
        @(negedge clk);
        req_valid = '0;
        chk("t1_tvalids", 64'({a_tvalid, b_tvalid}), 64'(2'b11));
        for (int i = 0; i < 40 && rsp_valid == '0; i++) @(negedge clk);
        chk("t1_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
        chk("t1_rsp_data", 64'(rsp_data), 64'(32'h40400000));
        repeat (2) @(negedge clk);
        chk("t1_idle", 64'(busy), 64'(0));

        // full contention
        do_reset();
        clr_logs();
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = 32'h41000000 + 32'(i);
            req_b[32*i +: 32] = 32'h3F800000 + 32'(i << 8);
        end
        req_valid = '1;
        for (int i = 0; i < 20 && gq.size() < 8; i++) @(negedge clk);
        req_valid = '0;
        chk("t2_ngrant", 64'(gq.size()), 64'(8));
        for (int k = 0; k < 8; k++) chk("t2_order", 64'(k < gq.size() ? gq[k] : 99), 64'(k % 4));
        chk("t2_rate", 64'(gq.size() == 8 ? gc[7] - gc[0] : -1), 64'(7));
        for (int i = 0; i < 80 && rq_d.size() < 8; i++) @(negedge clk);
        chk("t2_nrsp", 64'(rq_d.size()), 64'(8));
        for (int k = 0; k < 8; k++) begin
            chk("t2_rsp_id", 64'(k < rq_id.size() ? rq_id[k] : 99), 64'(k % 4));
            chk("t2_rsp_data", 64'(k < rq_d.size() ? rq_d[k] : 32'hDEADBEEF),
                64'(ip_div(32'h41000000 + 32'(k % 4), 32'h3F800000 + 32'((k % 4) << 8))));
        end

        // result backpressure up to the outstanding limit
        clr_logs();
        rsp_ready = '0;
        req_b[31:0] = 32'h12345678;
        req_valid = 4'b0001;
        for (int i = 0; i < 100; i++) begin
            req_a[31:0] = 32'h30000000 + 32'(gq.size());
            @(negedge clk);
        end
        chk("t3_res_tready", 64'(r_ready), 64'(0));
        chk("t3_req_ready", 64'(req_ready), 64'(0));
        chk("t3_busy", 64'(busy), 64'(1));
        chk("t3_ngrant", 64'(gq.size()), 64'(32));
        chk("t3_nrsp_held", 64'(rq_d.size()), 64'(0));
        req_valid = '0;
        rsp_ready = '1;
        for (int i = 0; i < 200 && rq_d.size() < 32; i++) @(negedge clk);
        chk("t3_nrsp", 64'(rq_d.size()), 64'(32));
        for (int k = 0; k < 32; k++) begin
            chk("t3_rsp_id", 64'(k < rq_id.size() ? rq_id[k] : 99), 64'(0));
            chk("t3_rsp_data", 64'(k < rq_d.size() ? rq_d[k] : 32'hDEADBEEF),
                64'(ip_div(32'h30000000 + 32'(k), 32'h12345678)));
        end

        // channel skew: divisor accepted at once, dividend held off
        clr_logs();
        begin
            int na0, nb0;
            na0 = na; nb0 = nb;
            req_a[63:32] = 32'h11110000;
            req_b[63:32] = 32'h00002222;
            a_rdy = 1'b0;
            req_valid = 4'b0010;
            @(negedge clk);
            req_valid = '0;
            chk("t4_grant", 64'(gq.size() == 1 ? gq[0] : 99), 64'(1));
            chk("t4_tv0", 64'({a_tvalid, b_tvalid}), 64'(2'b11));
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk("t4_tv_skew", 64'({a_tvalid, b_tvalid}), 64'(2'b10));
            end
            a_rdy = 1'b1;
            @(negedge clk);
            chk("t4_tv_done", 64'({a_tvalid, b_tvalid}), 64'(2'b00));
            chk("t4_na", 64'(na - na0), 64'(1));
            chk("t4_nb", 64'(nb - nb0), 64'(1));
            for (int i = 0; i < 40 && rq_d.size() < 1; i++) @(negedge clk);
            repeat (5) @(negedge clk);
            chk("t4_nrsp", 64'(rq_d.size()), 64'(1));
            chk("t4_rsp_id", 64'(rq_id.size() > 0 ? rq_id[0] : 99), 64'(1));
            chk("t4_rsp_data", 64'(rq_d.size() > 0 ? rq_d[0] : 32'h0), 64'(ip_div(32'h11110000, 32'h00002222)));
        end

        // mid-operation reset leaves three orphaned results
        clr_logs();
        n_orph = 0;
        req_a[95:64] = 32'h22220000;
        req_b[95:64] = 32'h00003333;
        req_valid = 4'b0100;
        for (int i = 0; i < 10 && gq.size() < 3; i++) @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        chk("t5_ngrant", 64'(gq.size()), 64'(3));
        chk("t5_busy", 64'(busy), 64'(1));
        rstn = 1'b0;
        @(negedge clk);
        chk("t5_rst_outs", 64'({req_ready, rsp_valid, a_tvalid, b_tvalid, busy, orphan}), 64'(0));
        rstn = 1'b1;
        repeat (30) @(negedge clk);
        chk("t5_orphans", 64'(n_orph), 64'(3));
        chk("t5_nrsp", 64'(rq_d.size()), 64'(0));
        chk("t5_idle", 64'(busy), 64'(0));

        // special value: 1.0 / 0.0 -> +Inf to requester 3
        req_a[127:96] = 32'h3F800000;
        req_b[127:96] = 32'h00000000;
        req_valid = 4'b1000;
        @(negedge clk);
        req_valid = '0;
        for (int i = 0; i < 40 && rsp_valid == '0; i++) @(negedge clk);
        chk("t6_rsp_valid", 64'(rsp_valid), 64'(4'b1000));
        chk("t6_rsp_data", 64'(rsp_data), 64'(32'h7F800000));
        repeat (3) @(negedge clk);

        chk("onehot", 64'(n_viol), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
